bcd_countdown_timer: RTL

- BCD countdown timer for the watch controller: MM:SS, counting down from a loaded value to 00:00.
- Counterpart to the up-counting stopwatch digit chain: decrement with a borrow chain instead of increment with a carry chain.
- Driven by an external 1 Hz tick enable. Feeds the display mux with four BCD digits and drives the alarm/buzzer logic.

---
 rtl/bcd_countdown_timer.sv | 101 ++++++++++
 1 files changed

// File: rtl/bcd_countdown_timer.sv
// bcd_countdown_timer: MM:SS BCD countdown with pause, alarm hold and optional auto-reload (COUNTDOWN_AUTO_RELOAD_EN)
module bcd_countdown_timer #(
  parameter int ALARM_LEN    = 8,
  parameter int MIN_TENS_MAX = 5
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        tick,
  input  logic        load,
  input  logic [15:0] load_value,
  input  logic        start_resume,
  input  logic        stop,
  input  logic        clear,
  output logic [15:0] digits,
  output logic        running,
  output logic        alarm,
  output logic        done_pulse
);
  typedef enum logic [1:0] {IDLE, RUNNING, PAUSED, EXPIRED} state_t;
  localparam logic [7:0] AL = 8'(ALARM_LEN);
  localparam logic [3:0] MT = 4'(MIN_TENS_MAX);
  state_t state, state_n;
  logic [15:0] digits_n, clamped, dec, reload;
  logic [7:0] cnt, cnt_n;
  logic done_n, b0, b1, b2;
  function automatic logic [3:0] clamp(input logic [3:0] d, input logic [3:0] m);
    return d > m ? m : d;
  endfunction
  assign clamped = {clamp(load_value[15:12], MT), clamp(load_value[11:8], 4'd9),
                    clamp(load_value[7:4], 4'd5), clamp(load_value[3:0], 4'd9)};
  assign b0 = digits[3:0] == 4'd0;
  assign b1 = b0 && digits[7:4] == 4'd0;
  assign b2 = b1 && digits[11:8] == 4'd0;
  assign dec = {b2 ? digits[15:12] - 4'd1 : digits[15:12],
                b1 ? (digits[11:8] == 4'd0 ? 4'd9 : digits[11:8] - 4'd1) : digits[11:8],
                b0 ? (digits[7:4] == 4'd0 ? 4'd5 : digits[7:4] - 4'd1) : digits[7:4],
                b0 ? 4'd9 : digits[3:0] - 4'd1};
`ifdef COUNTDOWN_AUTO_RELOAD_EN
  logic [15:0] shadow, shadow_n;
  assign reload = shadow;
  // shadow keeps the last accepted load so expiry can restart the count
  always_ff @(posedge clk)
    shadow <= reset ? 16'h0000 : shadow_n;
  // shadow follows clear and accepted loads only
  always_comb begin
    shadow_n = shadow;
    if (clear) shadow_n = 16'h0000;
    else if (load && state != RUNNING) shadow_n = clamped;
  end
`else
  assign reload = 16'h0000;
`endif
  // next-state logic in command priority order: clear, load, stop, start_resume, tick
  always_comb begin
    state_n  = state;
    digits_n = digits;
    cnt_n    = cnt;
    done_n   = 1'b0;
    if (clear) begin
      state_n  = IDLE;
      digits_n = 16'h0000;
      cnt_n    = 8'd0;
    end else if (load && state != RUNNING) begin
      state_n  = IDLE;
      digits_n = clamped;
      cnt_n    = 8'd0;
    end else if (stop) begin
      state_n = state == RUNNING ? PAUSED : state == EXPIRED ? IDLE : state;
      cnt_n   = 8'd0;
    end else if (start_resume && state != RUNNING) begin
      state_n = state == EXPIRED ? IDLE : digits != 16'h0000 ? RUNNING : state;
      cnt_n   = 8'd0;
    end else if (tick && state == RUNNING) begin
      done_n   = digits == 16'h0001;
      digits_n = !done_n ? dec : reload;
      state_n  = done_n && reload == 16'h0000 ? EXPIRED : RUNNING;
      cnt_n    = 8'd0;
    end else if (tick && state == EXPIRED) begin
      cnt_n   = cnt + 8'd1 == AL ? 8'd0 : cnt + 8'd1;
      state_n = cnt + 8'd1 == AL ? IDLE : EXPIRED;
    end
  end
  // all outputs registered from the next-state values
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      digits     <= 16'h0000;
      cnt        <= 8'd0;
      done_pulse <= 1'b0;
      running    <= 1'b0;
      alarm      <= 1'b0;
    end else begin
      state      <= state_n;
      digits     <= digits_n;
      cnt        <= cnt_n;
      done_pulse <= done_n;
      running    <= state_n == RUNNING;
      alarm      <= state_n == EXPIRED;
    end
  end
endmodule
